graph_flow_controller: RTL and testbench
========================================

Name: graph_flow_controller

Overview:
- Top-level application sequencer for the graphing calculator.
- Walks the flow splash → graph menu → per-graph coefficient entry → plot.
- Generates the one-cycle state_entry pulse consumed by the menu and entry modules, and latches the graph-type selection when the menu is confirmed.
- Provides long-press-centre "back to menu" and paces plot redraws with a frame tick.

Parameters:
- SPLASH_CYCLES, default 200_000_000: splash dwell before auto-advance (2 s at 100 MHz).
- HOLD_CYCLES, default 100_000_000: btnC continuous-hold length that triggers back-to-menu.
- FRAME_CYCLES, default 1_666_667: plot redraw period (60 Hz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btnC_debounced  in  1  debounced centre button.
- menu_confirmed  in  1  one-cycle confirm pulse from the menu logic.
- graph1_type  in  2  menu selection for graph 1 (0 poly, 1 cos, 2 sin).
- graph2_type  in  2  menu selection for graph 2.
- entry_done  in  1  one-cycle pulse from the coefficient-entry module.
- state  out  2  0 SPLASH, 1 MENU, 2 COEF, 3 PLOT.
- state_entry  out  1  high on the first cycle of any state visit, including COEF re-entry.
- active_graph  out  1  graph whose coefficients are being entered.
- active_type  out  2  latched type of active_graph.
- g1_type_lat  out  2  graph-1 type captured at confirm.
- g2_type_lat  out  2  graph-2 type captured at confirm.
- plot_enable  out  1  high while state==PLOT.
- frame_tick  out  1  one-cycle redraw strobe in PLOT.

Behaviour:
- Clocking and reset: single clk domain; reset is asynchronous and active-high. All outputs are registered except active_type.
- Reset values:
  - state=SPLASH, state_entry=0, active_graph=0, g1/g2_type_lat=0, plot_enable=0, frame_tick=0.
  - Cycle counter=0, hold counter=0, hold_armed=1.
  - btnC_prev=1, so a press held through reset release is not an edge.
- active_type = active_graph ? g2_type_lat : g1_type_lat (combinational mux).
- Edge detection: btnC_edge = btnC_debounced & ~btnC_prev; btnC_prev updates every cycle.
- state_entry:
  - Asserts in the cycle after any registered state change, or after a COEF→COEF re-entry.
  - Lasts exactly one cycle.
  - Never asserts in the first cycle after reset.
- SPLASH:
  - The cycle counter increments each cycle.
  - When the counter equals SPLASH_CYCLES-1, or on btnC_edge, go to MENU.
- MENU:
  - menu_confirmed with state_entry=0 → latch both graph types, active_graph←0, go to COEF.
  - menu_confirmed arriving while state_entry=1 is ignored.
- COEF:
  - entry_done with active_graph=0 → active_graph←1, state stays COEF, state_entry pulses next cycle.
  - entry_done with active_graph=1 → go to PLOT.
- PLOT:
  - plot_enable=1. The cycle counter starts at 0 on entry and wraps at FRAME_CYCLES-1.
  - frame_tick pulses in the cycle the counter wraps, i.e. the first tick comes FRAME_CYCLES cycles after entry.
- Back-to-menu (COEF or PLOT only):
  - The hold counter increments while btnC_debounced=1 and hold_armed=1.
  - When it reaches HOLD_CYCLES-1, go to MENU and clear hold_armed.
  - Any release clears the hold counter and sets hold_armed=1. One back per press; a held button does not re-fire in MENU.
  - Returning to MENU keeps the latched types and resets active_graph to 0.
- Counter clearing: the cycle counter clears on every state change. The hold counter clears on release and on leaving COEF/PLOT.
- Priority in the same cycle: back > entry_done > everything else.
  - A back in COEF discards a simultaneous entry_done.
  - A back in PLOT suppresses frame_tick.
- Inputs are ignored outside their owning state (entry_done outside COEF, menu_confirmed outside MENU).
- Counter width: $clog2 of the largest parameter + 1. No overflow is possible because counters saturate or wrap as specified.
- Reset mid-flow: state returns to SPLASH immediately and all latches clear.

Decomposition:
- Shared package `calc_pkg` holds:
  - State encodings (ST_SPLASH..ST_PLOT).
  - Graph-type constants (GT_POLY=0, GT_COS=1, GT_SIN=2), shared with the menu module.
- One sub-module, `hold_detector` (press-hold counter with an arming flag, output back_pulse), reused later for other long-press functions.

Test Plan (SPLASH_CYCLES=10, HOLD_CYCLES=5, FRAME_CYCLES=4):
- Release reset with no buttons pressed → state=MENU 10 cycles later, state_entry high exactly one cycle. Repeat with btnC held across reset → still no early advance.
- In MENU: pulse menu_confirmed with graph1_type=1, graph2_type=2 → state=COEF, g1_type_lat=1, g2_type_lat=2, active_type=1. A confirm pulse in a MENU state_entry cycle → ignored.
- In COEF: entry_done → active_graph=1, active_type=2, state_entry pulses while state stays COEF. Second entry_done → state=PLOT, plot_enable=1.
- In PLOT for 12 cycles → frame_tick at cycles 4, 8, 12 after entry, each one cycle wide.
- In PLOT: hold btnC 5 cycles → state=MENU. Keep holding 20 more cycles → no further effect. Releasing 2 cycles into a hold → no transition.
- In COEF: entry_done in the same cycle the hold completes → state=MENU, active_graph=0. Assert reset mid-PLOT → state=SPLASH asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the graphing calculator: application states and graph types.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_MENU   = 2'd1,
    ST_COEF   = 2'd2,
    ST_PLOT   = 2'd3
  } state_t;

  localparam logic [1:0] GT_POLY = 2'd0;
  localparam logic [1:0] GT_COS  = 2'd1;
  localparam logic [1:0] GT_SIN  = 2'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hold_detector.sv
// Long-press detector: fires back_pulse_o once when btn_i has been held for HOLD_CYCLES
// enabled cycles; re-arms only after a release.
module hold_detector #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic btn_i,
  output logic back_pulse_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  assign back_pulse_o = en_i & btn_i & armed_q & (cnt_q == HOLD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (!btn_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (!en_i) begin
      cnt_q   <= '0;
    end else if (armed_q) begin
      if (back_pulse_o) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/graph_flow_controller.sv
// Application sequencer: splash -> menu -> coefficient entry (two graphs) -> plot,
// with long-press back-to-menu and frame pacing while plotting.
module graph_flow_controller
  import calc_pkg::*;
#(
  parameter int SPLASH_CYCLES = 200_000_000,
  parameter int HOLD_CYCLES   = 100_000_000,
  parameter int FRAME_CYCLES  = 1_666_667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnC_debounced,
  input  logic       menu_confirmed,
  input  logic [1:0] graph1_type,
  input  logic [1:0] graph2_type,
  input  logic       entry_done,
  output logic [1:0] state,
  output logic       state_entry,
  output logic       active_graph,
  output logic [1:0] active_type,
  output logic [1:0] g1_type_lat,
  output logic [1:0] g2_type_lat,
  output logic       plot_enable,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(max3(SPLASH_CYCLES, HOLD_CYCLES, FRAME_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] SPLASH_LAST = CNT_W'(SPLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             entry_q, active_q, plot_q, tick_q, btn_prev_q;
  logic [1:0]       g1_q, g2_q;
  logic             btn_edge, back;

  assign btn_edge = btnC_debounced & ~btn_prev_q;

  hold_detector #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .en_i        ((state_q == ST_COEF) || (state_q == ST_PLOT)),
    .btn_i       (btnC_debounced),
    .back_pulse_o(back)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SPLASH;
      cnt_q      <= '0;
      entry_q    <= 1'b0;
      active_q   <= 1'b0;
      plot_q     <= 1'b0;
      tick_q     <= 1'b0;
      g1_q       <= GT_POLY;
      g2_q       <= GT_POLY;
      btn_prev_q <= 1'b1;
    end else begin
      btn_prev_q <= btnC_debounced;
      entry_q    <= 1'b0;
      tick_q     <= 1'b0;
      unique case (state_q)
        ST_SPLASH: begin
          if (cnt_q == SPLASH_LAST || btn_edge) begin
            state_q <= ST_MENU;
            entry_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_MENU: begin
          // A confirm landing on the entry cycle is a leftover from the previous screen.
          if (menu_confirmed && !entry_q) begin
            g1_q     <= graph1_type;
            g2_q     <= graph2_type;
            active_q <= 1'b0;
            state_q  <= ST_COEF;
            entry_q  <= 1'b1;
          end
        end
        ST_COEF: begin
          if (back) begin
            state_q  <= ST_MENU;
            entry_q  <= 1'b1;
            active_q <= 1'b0;
          end else if (entry_done) begin
            entry_q <= 1'b1;
            if (!active_q) begin
              active_q <= 1'b1;
            end else begin
              state_q <= ST_PLOT;
              plot_q  <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        ST_PLOT: begin
          if (back) begin
            state_q  <= ST_MENU;
            entry_q  <= 1'b1;
            active_q <= 1'b0;
            plot_q   <= 1'b0;
            cnt_q    <= '0;
          end else if (cnt_q == FRAME_LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SPLASH;
      endcase
    end
  end

  assign state        = state_q;
  assign state_entry  = entry_q;
  assign active_graph = active_q;
  assign active_type  = active_q ? g2_q : g1_q;
  assign g1_type_lat  = g1_q;
  assign g2_type_lat  = g2_q;
  assign plot_enable  = plot_q;
  assign frame_tick   = tick_q;

endmodule

// File: tb/tb_graph_flow_controller.sv
// Directed bench for graph_flow_controller with short dwell/hold/frame periods.
module tb_graph_flow_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnC_debounced = 1'b0;
  logic       menu_confirmed = 1'b0;
  logic [1:0] graph1_type = 2'd0;
  logic [1:0] graph2_type = 2'd0;
  logic       entry_done = 1'b0;
  logic [1:0] state;
  logic       state_entry, active_graph, plot_enable, frame_tick;
  logic [1:0] active_type, g1_type_lat, g2_type_lat;

  int nvec = 0;
  int nerr = 0;

  graph_flow_controller #(
    .SPLASH_CYCLES(10),
    .HOLD_CYCLES  (5),
    .FRAME_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btnC_debounced(btnC_debounced),
    .menu_confirmed(menu_confirmed),
    .graph1_type   (graph1_type),
    .graph2_type   (graph2_type),
    .entry_done    (entry_done),
    .state         (state),
    .state_entry   (state_entry),
    .active_graph  (active_graph),
    .active_type   (active_type),
    .g1_type_lat   (g1_type_lat),
    .g2_type_lat   (g2_type_lat),
    .plot_enable   (plot_enable),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_done();
    entry_done = 1'b1;
    step();
    entry_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".entry"}, state_entry, 0);
    chk({tag, ".ag"}, active_graph, 0);
    chk({tag, ".g1"}, g1_type_lat, 0);
    chk({tag, ".g2"}, g2_type_lat, 0);
    chk({tag, ".plot"}, plot_enable, 0);
    chk({tag, ".tick"}, frame_tick, 0);
  endtask

  initial begin
    // Reset, then splash auto-advance after 10 cycles
    step(2);
    reset = 1'b0;
    chk_reset_vals("rst");
    step(9);
    chk("splash_9", state, 0);
    chk("splash_9_entry", state_entry, 0);
    step();
    chk("splash_10", state, 1);
    chk("menu_entry", state_entry, 1);
    step();
    chk("menu_entry_1cyc", state_entry, 0);
    chk("menu_stays", state, 1);

    // Button held through reset release is not an edge
    reset = 1'b1;
    btnC_debounced = 1'b1;
    step(2);
    reset = 1'b0;
    step(9);
    chk("held_splash_9", state, 0);
    step();
    chk("held_splash_10", state, 1);
    chk("held_menu_entry", state_entry, 1);

    // Confirm during entry cycle ignored, next cycle accepted
    btnC_debounced = 1'b0;
    menu_confirmed = 1'b1;
    graph1_type = 2'd1;
    graph2_type = 2'd2;
    step();
    chk("confirm_ignored_state", state, 1);
    chk("confirm_ignored_g1", g1_type_lat, 0);
    step();
    menu_confirmed = 1'b0;
    chk("coef_state", state, 2);
    chk("coef_entry", state_entry, 1);
    chk("coef_g1", g1_type_lat, 1);
    chk("coef_g2", g2_type_lat, 2);
    chk("coef_atype", active_type, 1);
    chk("coef_ag", active_graph, 0);

    // First entry_done: re-entry of COEF for graph 2
    pulse_done();
    chk("reentry_state", state, 2);
    chk("reentry_entry", state_entry, 1);
    chk("reentry_ag", active_graph, 1);
    chk("reentry_atype", active_type, 2);
    step();
    chk("reentry_entry_1cyc", state_entry, 0);

    // Second entry_done: PLOT, ticks every 4 cycles
    pulse_done();
    chk("plot_state", state, 3);
    chk("plot_en", plot_enable, 1);
    chk("plot_entry", state_entry, 1);
    chk("plot_tick0", frame_tick, 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("tick_c%0d", c), frame_tick, (c % 4 == 0) ? 1 : 0);
    end

    // Hold for 5 cycles; back lands on a wrap edge and must suppress that tick
    step(3);
    btnC_debounced = 1'b1;
    step();
    chk("hold_c16_tick", frame_tick, 1);
    step(3);
    chk("hold_c19_state", state, 3);
    step();
    chk("back_state", state, 1);
    chk("back_tick_supp", frame_tick, 0);
    chk("back_entry", state_entry, 1);
    chk("back_plot_en", plot_enable, 0);
    chk("back_ag", active_graph, 0);
    chk("back_g1_kept", g1_type_lat, 1);
    step(20);
    chk("held_no_refire", state, 1);
    chk("held_no_entry", state_entry, 0);
    btnC_debounced = 1'b0;
    step();

    // Interrupted holds in COEF do not accumulate
    menu_confirmed = 1'b1;
    step();
    menu_confirmed = 1'b0;
    chk("coef2_state", state, 2);
    btnC_debounced = 1'b1;
    step(2);
    btnC_debounced = 1'b0;
    step();
    btnC_debounced = 1'b1;
    step(3);
    btnC_debounced = 1'b0;
    step();
    chk("short_hold_state", state, 2);

    // Back wins over simultaneous entry_done
    btnC_debounced = 1'b1;
    step(4);
    chk("pre_back_state", state, 2);
    pulse_done();
    btnC_debounced = 1'b0;
    chk("prio_state", state, 1);
    chk("prio_ag", active_graph, 0);
    chk("prio_g2_kept", g2_type_lat, 2);
    step();

    // Async reset mid-PLOT
    menu_confirmed = 1'b1;
    step();
    menu_confirmed = 1'b0;
    pulse_done();
    pulse_done();
    chk("plot2_state", state, 3);
    step(2);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_rst");
    step();
    reset = 1'b0;
    step();
    chk("post_rst_state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
